// File: rtl/seq_packet_sender.sv
// Transmit side of the sequenced packet link: turns one message into [hdr][seq][data...] 32-bit words
// and keeps a per-stream sequence counter that advances once the final word of a packet is accepted.
module seq_packet_sender #(
  parameter int NUM_STREAMS = 32,
  parameter int MAX_PAYLOAD = 37
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic [0:8*MAX_PAYLOAD-1]   msgIn_data,
  input  logic [5:0]                 msgIn_len,
  input  logic [15:0]                msgIn_stream,
  input  logic                       msgIn_val,
  output logic                       msgIn_ready,
  output logic [31:0]                dataOut,
  output logic                       dataOut_val,
  input  logic                       dataOut_ready,
  output logic                       dataOut_last,
  output logic                       lenError
);

  localparam int IDXW = $clog2(NUM_STREAMS);
  localparam int MAXW = (MAX_PAYLOAD + 3) / 4;
  localparam int DW   = 32 * MAXW;
  localparam int WCW  = $clog2(MAXW + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_SEQ, S_DATA} state_e;

  state_e           state_q, state_d;
  logic [0:DW-1]    data_q, data_msk;
  logic [5:0]       len_q;
  logic [15:0]      stream_q;
  logic [31:0]      seq_q;
  logic [WCW-1:0]   wcnt_q, nw_q, nw_in;
  logic             lenerr_q;
  logic [31:0]      seq_tbl_q [NUM_STREAMS];
  logic [31:0]      seq_rd;
  logic [15:0]      hdr_len;
  logic             accept, len_ok, fire, last_word;

  assign accept    = msgIn_val & msgIn_ready;
  assign len_ok    = (msgIn_len != 6'd0) && (msgIn_len <= 6'(MAX_PAYLOAD));
  assign fire      = dataOut_val & dataOut_ready;
  assign last_word = (state_q == S_DATA) && (wcnt_q == nw_q - WCW'(1));
  assign seq_rd    = seq_tbl_q[msgIn_stream[IDXW-1:0]];
  assign hdr_len   = 16'(len_q) + 16'd8;
  assign nw_in     = WCW'(({1'b0, msgIn_len} + 7'd3) >> 2);

  // Bytes past the message length are zeroed once at accept so the data mux stays trivial.
  always_comb begin
    data_msk = '0;
    for (int i = 0; i < MAX_PAYLOAD; i++)
      if (i < int'(msgIn_len)) data_msk[8*i +: 8] = msgIn_data[8*i +: 8];
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && len_ok) state_d = S_HDR;
      S_HDR:  if (fire) state_d = S_SEQ;
      S_SEQ:  if (fire) state_d = S_DATA;
      S_DATA: if (fire && last_word) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msgIn_ready  = (state_q == S_IDLE);
    dataOut_val  = (state_q != S_IDLE);
    dataOut_last = last_word;
    dataOut      = '0;
    case (state_q)
      S_HDR:   dataOut = {hdr_len[7:0], hdr_len[15:8], stream_q[7:0], stream_q[15:8]};
      S_SEQ:   dataOut = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
      S_DATA:  dataOut = data_q[32*int'(wcnt_q) +: 32];
      default: dataOut = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_q   <= '0;
      len_q    <= '0;
      stream_q <= '0;
      seq_q    <= '0;
      nw_q     <= '0;
      wcnt_q   <= '0;
      lenerr_q <= 1'b0;
    end else begin
      lenerr_q <= accept & ~len_ok;
      if (accept && len_ok) begin
        data_q   <= data_msk;
        len_q    <= msgIn_len;
        stream_q <= msgIn_stream;
        seq_q    <= seq_rd;
        nw_q     <= nw_in;
        wcnt_q   <= '0;
      end else if (fire && state_q == S_DATA) begin
        wcnt_q <= wcnt_q + WCW'(1);
      end
    end
  end

  // Committing the increment only on the last-word handshake keeps an aborted packet from consuming a number.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NUM_STREAMS; i++) seq_tbl_q[i] <= '0;
    end else if (fire && last_word) begin
      seq_tbl_q[stream_q[IDXW-1:0]] <= seq_q + 32'd1;
    end
  end

  assign lenError = lenerr_q;

endmodule
